count_dn_timer: RTL and testbench

COUNT_DN_TIMER -- requirements
Module: count_dn_timer

---
 rtl/count_pkg.sv | 15 +
 rtl/cnt_dec_cell.sv | 34 +++
 rtl/count_dn_timer.sv | 120 ++++++++++++
 tb/tb_count_dn_timer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg
//   Shared definitions for the count-down timer slice.
//   - WIDTH_DEF : default counter width in bits.
//   - state_t   : timer state encoding (IDLE, RUN, DONE).
package count_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : count_pkg

// File: rtl/cnt_dec_cell.sv
// cnt_dec_cell
//   Combinational helper for the count-down timer.
//   Ports:
//     cnt     in  WIDTH  current count
//     cnt_dec out WIDTH  cnt - 1 (modulo 2^WIDTH)
//     is_one  out 1      high when cnt == 1
//   WIDTH must be at least 2.
module cnt_dec_cell #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_dec,
    output logic             is_one
);

    // Ripple-borrow decrement: bit i flips while every lower bit is zero.
    logic [WIDTH-1:0] borrow;

    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_dec
            assign cnt_dec[gi] = cnt[gi] ^ borrow[gi];
            if (gi < WIDTH - 1) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & ~cnt[gi];
            end
        end
    endgenerate

    // Terminal step is taken from 1, so only bit 0 may be set.
    assign is_one = cnt[0] & ~(|cnt[WIDTH-1:1]);

endmodule : cnt_dec_cell

// File: rtl/count_dn_timer.sv
// count_dn_timer
//   Loadable count-down timer with one-shot or auto-reload behaviour.
//   Ports:
//     clk      in  1      rising-edge clock
//     rst      in  1      synchronous active-high reset
//     clr      in  1      synchronous clear back to IDLE
//     load     in  1      load strobe (captures load_val)
//     load_val in  WIDTH  start value / reload period
//     en       in  1      count enable while running
//     reload   in  1      1 = auto-reload at terminal count, 0 = one-shot
//     ack      in  1      acknowledges done, returns to IDLE
//     cnt      out WIDTH  current count (registered)
//     tc       out 1      terminal-count pulse (registered, one cycle)
//     busy     out 1      state is RUN (registered)
//     done     out 1      state is DONE (registered)
//   Priority each cycle: rst > clr > load > ack > count.
module count_dn_timer
    import count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             reload,
    input  logic             ack,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             tc_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] cnt_dec;
    logic             cnt_is_one;

    cnt_dec_cell #(
        .WIDTH (WIDTH)
    ) u_dec (
        .cnt     (cnt_reg),
        .cnt_dec (cnt_dec),
        .is_one  (cnt_is_one)
    );

    // busy/done are kept as their own flops, written alongside state_reg,
    // so every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            reload_reg <= '0;
            tc_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (load) begin
            cnt_reg    <= load_val;
            reload_reg <= load_val;
            if (load_val != '0) begin
                // Restarts any count in progress without a tc.
                state_reg <= RUN;
                tc_reg    <= 1'b0;
                busy_reg  <= 1'b1;
                done_reg  <= 1'b0;
            end else begin
                // A zero period expires immediately.
                state_reg <= DONE;
                tc_reg    <= 1'b1;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
            end
        end else begin
            tc_reg <= 1'b0;
            unique case (state_reg)
                DONE: begin
                    if (ack) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (cnt_is_one) begin
                            tc_reg <= 1'b1;
                            // reload only matters at this terminal step.
                            if (reload) begin
                                cnt_reg <= reload_reg;
                            end else begin
                                cnt_reg   <= '0;
                                state_reg <= DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            cnt_reg <= cnt_dec;
                        end
                    end
                end
                default: begin
                    // IDLE: hold count, ignore en and ack.
                end
            endcase
        end
    end

    assign cnt  = cnt_reg;
    assign tc   = tc_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule : count_dn_timer

// File: tb/tb_count_dn_timer.sv
module tb_count_dn_timer;

    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst, clr, load, en, reload, ack;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt;
    logic         tc, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = idle, 1 = running, 2 = finished.
    int m_mode;
    int m_cnt;
    int m_per;
    int m_tc;

    count_dn_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .reload   (reload),
        .ack      (ack),
        .cnt      (cnt),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update();
        if (rst || clr) begin
            m_mode = 0; m_cnt = 0; m_per = 0; m_tc = 0;
        end else if (load) begin
            m_cnt = int'(load_val);
            m_per = int'(load_val);
            m_tc  = (load_val == 0) ? 1 : 0;
            m_mode = (load_val == 0) ? 2 : 1;
        end else begin
            m_tc = 0;
            if (m_mode == 2 && ack) begin
                m_mode = 0;
            end else if (m_mode == 1 && en) begin
                if (m_cnt == 1) begin
                    m_tc = 1;
                    if (reload) m_cnt = m_per;
                    else begin
                        m_cnt = 0;
                        m_mode = 2;
                    end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; clr = 0; load = 0; ack = 0; en = 0; reload = 0; load_val = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: cnt=%0d tc=%b busy=%b done=%b, expected all 0", cnt, tc, busy, done);
        end
        $display("reset: cnt=%0d tc=%b busy=%b done=%b", cnt, tc, busy, done);
    endtask

    task automatic test_oneshot();
        logic [W-1:0] exp_seq [4];
        exp_seq = '{8'd3, 8'd2, 8'd1, 8'd0};
        idle_inputs();
        load = 1; load_val = 8'd3; en = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            load = 0;
            n_checks++;
            if ({cnt, tc, busy, done} !== {exp_seq[k], (k == 3), (k != 3), (k == 3)}) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d", k, cnt, tc, busy, done, exp_seq[k]);
            end
            $display("oneshot[%0d]: cnt=%0d tc=%b busy=%b done=%b", k, cnt, tc, busy, done);
        end
        en = 0;
        step();
        n_checks++;
        if ({tc, busy, done} !== 3'b001) begin
            n_fail++;
            $display("FAIL oneshot_hold: tc=%b busy=%b done=%b, expected 0 0 1", tc, busy, done);
        end
        ack = 1;
        step();
        ack = 0;
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL oneshot_ack: cnt=%0d tc=%b busy=%b done=%b, expected idle", cnt, tc, busy, done);
        end
        $display("oneshot_ack: busy=%b done=%b", busy, done);
    endtask

    task automatic test_autoreload();
        int pulses = 0;
        int exp_c;
        idle_inputs();
        load = 1; load_val = 8'd4; reload = 1; en = 1;
        step();
        load = 0;
        n_checks++;
        if (cnt !== 8'd4 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL autoreload_load: cnt=%0d tc=%b, expected 4 0", cnt, tc);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_c = 4 - (k % 4);
            if (tc) pulses++;
            n_checks++;
            if (cnt !== W'(exp_c) || tc !== (exp_c == 4) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL autoreload[%0d]: cnt=%0d tc=%b busy=%b, expected cnt=%0d", k, cnt, tc, busy, exp_c);
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL autoreload_pulses: got %0d, expected 3", pulses);
        end
        $display("autoreload: pulses=%0d", pulses);
        clr = 1; en = 0; reload = 0;
        step();
        clr = 0;
    endtask

    task automatic test_enable_gaps();
        logic [W-1:0] exp_seq [4];
        logic         en_seq [4];
        exp_seq = '{8'd4, 8'd4, 8'd4, 8'd3};
        en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1};
        idle_inputs();
        load = 1; load_val = 8'd5;
        step();
        load = 0;
        for (int k = 0; k < 4; k++) begin
            en = en_seq[k];
            step();
            n_checks++;
            if (cnt !== exp_seq[k] || tc !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL en_gap[%0d]: cnt=%0d tc=%b busy=%b, expected cnt=%0d", k, cnt, tc, busy, exp_seq[k]);
            end
            $display("en_gap[%0d]: en=%b cnt=%0d tc=%b", k, en, cnt, tc);
        end
    endtask

    task automatic test_restart_and_clr();
        idle_inputs();
        load = 1; load_val = 8'd6; en = 1;
        step();
        load = 0;
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if (cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL restart_pre: cnt=%0d, expected 2", cnt);
        end
        load = 1; load_val = 8'd9;
        step();
        load = 0;
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd9, 3'b010}) begin
            n_fail++;
            $display("FAIL restart: cnt=%0d tc=%b busy=%b done=%b, expected 9 0 1 0", cnt, tc, busy, done);
        end
        $display("restart: cnt=%0d busy=%b", cnt, busy);
        step();
        step();
        clr = 1;
        step();
        clr = 0;
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL clr: cnt=%0d tc=%b busy=%b done=%b, expected all 0", cnt, tc, busy, done);
        end
        step();
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL clr_idle_en: cnt=%0d tc=%b busy=%b done=%b, expected idle", cnt, tc, busy, done);
        end
        $display("clr: cnt=%0d busy=%b", cnt, busy);
    endtask

    task automatic test_zero_load();
        idle_inputs();
        load = 1; load_val = 8'd0;
        step();
        load = 0;
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd0, 3'b101}) begin
            n_fail++;
            $display("FAIL zero_load: cnt=%0d tc=%b busy=%b done=%b, expected 0 1 0 1", cnt, tc, busy, done);
        end
        step();
        n_checks++;
        if ({tc, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_load_pulse: tc=%b done=%b, expected 0 1", tc, done);
        end
        load = 1; load_val = 8'd7; ack = 1;
        step();
        load = 0; ack = 0;
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd7, 3'b010}) begin
            n_fail++;
            $display("FAIL load_over_ack: cnt=%0d tc=%b busy=%b done=%b, expected 7 0 1 0", cnt, tc, busy, done);
        end
        $display("load_over_ack: cnt=%0d busy=%b done=%b", cnt, busy, done);
    endtask

    task automatic test_rst_mid_run();
        idle_inputs();
        load = 1; load_val = 8'd2; en = 1;
        step();
        load = 0;
        step();
        n_checks++;
        if (cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: cnt=%0d, expected 1", cnt);
        end
        rst = 1;
        step();
        rst = 0; en = 0;
        n_checks++;
        if ({cnt, tc, busy, done} !== {8'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL rst_mid: cnt=%0d tc=%b busy=%b done=%b, expected all 0", cnt, tc, busy, done);
        end
        $display("rst_mid: cnt=%0d tc=%b", cnt, tc);
    endtask

    task automatic test_max_value();
        int tcs = 0;
        idle_inputs();
        load = 1; load_val = W'(MAXV); en = 1;
        step();
        load = 0;
        for (int k = 1; k <= MAXV; k++) begin
            step();
            if (tc) tcs++;
            n_checks++;
            if (cnt !== W'(MAXV - k)) begin
                n_fail++;
                $display("FAIL max_count[%0d]: cnt=%0d, expected %0d", k, cnt, MAXV - k);
            end
        end
        n_checks++;
        if (tcs != 1 || tc !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL max_end: tc_count=%0d tc=%b done=%b, expected 1 1 1", tcs, tc, done);
        end
        $display("max_value: final cnt=%0d tc_pulses=%0d", cnt, tcs);
        en = 0; ack = 1;
        step();
        ack = 0;
    endtask

    task automatic test_random();
        int errs_before = n_fail;
        idle_inputs();
        for (int k = 0; k < 600; k++) begin
            rst    = ($urandom_range(0, 99) < 2);
            clr    = ($urandom_range(0, 99) < 3);
            load   = ($urandom_range(0, 99) < 10);
            load_val = ($urandom_range(0, 7) == 0) ? W'(MAXV) : W'($urandom_range(0, 6));
            en     = ($urandom_range(0, 3) != 0);
            reload = $urandom_range(0, 1) == 1;
            ack    = ($urandom_range(0, 3) == 0);
            step();
            n_checks++;
            if (cnt !== W'(m_cnt) || tc !== (m_tc == 1) || busy !== (m_mode == 1) || done !== (m_mode == 2)) begin
                n_fail++;
                $display("FAIL random[%0d]: cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%0d mode=%0d",
                         k, cnt, tc, busy, done, m_cnt, m_tc, m_mode);
            end
        end
        $display("random: 600 cycles, %0d new failures", n_fail - errs_before);
        idle_inputs();
    endtask

    initial begin
        m_mode = 0; m_cnt = 0; m_per = 0; m_tc = 0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_enable_gaps();
        test_restart_and_clr();
        test_zero_load();
        test_rst_mid_run();
        test_max_value();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_count_dn_timer
